w_74hc_gate_bank: RTL and testbench
===================================

Name: w_74hc_gate_bank

Overview:
- Parametrised, registered successor to the quad 2-input NAND lab block.
- N_CH independent 2-input gate channels share one run-time-selectable logic function. Outputs are registered.
- A built-in truth-table self-test FSM sweeps all four input combinations on every channel and reports per-channel failures.
- Sits at the board pin level of the gate-experiment designs.
- An inject_fault port exists so the tester itself can be exercised.

Parameters:
- N_CH, 4, number of gate channels (1..16).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- A  in  N_CH  channel input A (A[i] feeds channel i)
- B  in  N_CH  channel input B
- fn_sel  in  3  function code; encoding in package
- fn_load  in  1  one-cycle strobe: latch fn_sel into active function
- inject_fault  in  N_CH  inverts core output of channel i (test hook)
- test_start  in  1  one-cycle strobe: begin self-test
- Y  out  N_CH  registered gate outputs
- active_fn  out  3  currently applied function code
- test_busy  out  1  self-test in progress
- test_done  out  1  one-cycle pulse at end of self-test
- test_pass  out  1  result of last self-test, sticky
- fail_ch  out  N_CH  per-channel failure flags of last self-test, sticky

Behaviour:
- Reset (rst_n=0 at a clk edge): Y=0, active_fn=3'b000 (NAND), test_busy=0, test_done=0, test_pass=0, fail_ch=0, FSM=IDLE, vector counter=0. Reset mid-test aborts the test with no done pulse.
- Function codes: 000 NAND, 001 AND, 010 NOR, 011 OR, 100 XOR, 101 XNOR, 110 NOT A, 111 BUF A.
- fn_load:
  - Sampled only when the FSM is in IDLE; active_fn <= fn_sel at that edge.
  - The new function applies to Y computed from the next edge onward.
  - Ignored while test_busy=1 or in DONE.
- Normal mode (FSM=IDLE or DONE): each edge, Y[i] <= f(A[i],B[i]) XOR inject_fault[i]. Latency is 1 cycle from A/B to Y.
- Self-test mode: Y holds its last normal-mode value; A and B are ignored.
- Core output register core_q[i] <= f(a_int,b_int) XOR inject_fault[i]. It runs in all modes; in normal mode a_int=A and b_int=B.
- FSM states: IDLE, APPLY, CHECK, DONE.
  - IDLE: on test_start=1, go to APPLY, vec<=0, fail_ch<=0, test_pass<=0. fn_load and test_start in the same cycle: both take effect; the test uses the new function.
  - APPLY: a_int=vec[1], b_int=vec[0] on all channels; go to CHECK.
  - CHECK: fail_ch[i] <= fail_ch[i] | (core_q[i] != golden(active_fn,vec[1],vec[0])).
    - If vec==3, go to DONE.
    - Otherwise vec<=vec+1 (2-bit, no wrap needed) and go to APPLY.
  - DONE: test_done=1 for exactly this cycle; test_pass <= ~|fail_ch (including the final CHECK update); go to IDLE.
- test_busy=1 exactly in APPLY and CHECK. test_start while not in IDLE is ignored.
- Timing: test_start sampled at edge t → busy during cycles t+1..t+8 → test_done high in cycle t+9 → IDLE at t+10.
- fail_ch and test_pass hold until the next test_start or reset.
- golden() is an independent package function, not shared with the datapath cell, so a datapath decode bug is detectable.

Decomposition:
- Package w_gate_pkg:
  - FN_W=3
  - localparams FN_NAND..FN_BUFA
  - FSM state enum (IDLE, APPLY, CHECK, DONE)
  - function golden(fn,a,b)
- Sub-module w_gate_cell: one 1-bit combinational gate with fn input, instantiated N_CH times by generate.
- FSM, counter, registers and compare logic live in the top module.

Test Plan:
- Reset then A=4'b1010, B=4'b1100, no load → one cycle later Y=4'b0111 (NAND), active_fn=000, test_pass=0, fail_ch=0.
- fn_load with fn_sel=100 (XOR), A=4'b1010, B=4'b1100 → active_fn=100 next cycle; the following cycle Y=4'b0110. Repeat with 010 (NOR) → Y=4'b0001.
- test_start with fn=000, inject_fault=0 → test_busy high for 8 cycles; test_done single pulse at t+9; test_pass=1, fail_ch=4'b0000; Y unchanged throughout.
- test_start with inject_fault=4'b0100 → test_done at t+9, test_pass=0, fail_ch=4'b0100. Then a new test_start with inject_fault=0 → fail_ch cleared, test_pass=1.
- During a test, pulse fn_load (fn_sel=011) and a second test_start at t+3 → active_fn unchanged, no restart, done still at t+9. Assert rst_n=0 at t+5 → all outputs at reset values, no test_done pulse.
- Same-cycle fn_load (fn_sel=101 XNOR) and test_start → active_fn=101, test passes against the XNOR truth table, test_pass=1.

Source files
------------

// File: rtl/w_gate_pkg.sv
// Shared types and constants for the gate bank: function codes, self-test FSM states, reference truth tables.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package w_gate_pkg;

    localparam int FN_W = 3;

    localparam logic [FN_W-1:0] FN_NAND = 3'b000;
    localparam logic [FN_W-1:0] FN_AND  = 3'b001;
    localparam logic [FN_W-1:0] FN_NOR  = 3'b010;
    localparam logic [FN_W-1:0] FN_OR   = 3'b011;
    localparam logic [FN_W-1:0] FN_XOR  = 3'b100;
    localparam logic [FN_W-1:0] FN_XNOR = 3'b101;
    localparam logic [FN_W-1:0] FN_NOTA = 3'b110;
    localparam logic [FN_W-1:0] FN_BUFA = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } st_t;

    // Reference model built from truth-table constants, deliberately unlike the
    // boolean decode in w_gate_cell so a decode error in the cell shows up as a
    // self-test failure. The table is indexed by {a,b}.
    function automatic logic golden(input logic [FN_W-1:0] fn, input logic a, input logic b);
        logic [3:0] tt;
        case (fn)
            FN_NAND: tt = 4'b0111;
            FN_AND:  tt = 4'b1000;
            FN_NOR:  tt = 4'b0001;
            FN_OR:   tt = 4'b1110;
            FN_XOR:  tt = 4'b0110;
            FN_XNOR: tt = 4'b1001;
            FN_NOTA: tt = 4'b0011;
            FN_BUFA: tt = 4'b1100;
            default: tt = 4'b0000;
        endcase
        return tt[{a, b}];
    endfunction

endpackage

// File: rtl/w_gate_cell.sv
// One 2-input gate whose function is chosen by fn.
// Latency: combinational.
// Backpressure: none.
module w_gate_cell
    import w_gate_pkg::*;
(
    input  logic [FN_W-1:0] fn,
    input  logic            a,
    input  logic            b,
    output logic            y
);

    // Decode the function code into the gate output.
    always_comb begin
        y = 1'b0;
        case (fn)
            FN_NAND: y = ~(a & b);
            FN_AND:  y = a & b;
            FN_NOR:  y = ~(a | b);
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            FN_XNOR: y = ~(a ^ b);
            FN_NOTA: y = ~a;
            FN_BUFA: y = a;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/w_74hc_gate_bank.sv
// Bank of N_CH registered 2-input gates sharing one selectable function, with a truth-table self-test.
// Latency: 1 cycle A/B to Y; self-test runs 8 busy cycles then a 1-cycle done pulse.
// Backpressure: none; strobes arriving outside IDLE are dropped.
module w_74hc_gate_bank
    import w_gate_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  A,
    input  logic [N_CH-1:0]  B,
    input  logic [FN_W-1:0]  fn_sel,
    input  logic             fn_load,
    input  logic [N_CH-1:0]  inject_fault,
    input  logic             test_start,
    output logic [N_CH-1:0]  Y,
    output logic [FN_W-1:0]  active_fn,
    output logic             test_busy,
    output logic             test_done,
    output logic             test_pass,
    output logic [N_CH-1:0]  fail_ch
);

    st_t             state_q;
    st_t             state_d;
    logic [1:0]      vec_q;
    logic [N_CH-1:0] a_int;
    logic [N_CH-1:0] b_int;
    logic [N_CH-1:0] cell_y;
    logic [N_CH-1:0] core_q;
    logic [N_CH-1:0] mismatch;
    logic            golden_bit;
    logic            normal_mode;

    assign normal_mode = (state_q == IDLE) || (state_q == DONE);
    assign test_busy   = (state_q == APPLY) || (state_q == CHECK);
    assign test_done   = (state_q == DONE);
    assign golden_bit  = golden(active_fn, vec_q[1], vec_q[0]);
    assign mismatch    = core_q ^ {N_CH{golden_bit}};

    // Drive the gate inputs from the pins, or broadcast the test vector while applying it.
    always_comb begin
        a_int = A;
        b_int = B;
        if (state_q == APPLY) begin
            a_int = {N_CH{vec_q[1]}};
            b_int = {N_CH{vec_q[0]}};
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_cell
        w_gate_cell u_cell (
            .fn (active_fn),
            .a  (a_int[i]),
            .b  (b_int[i]),
            .y  (cell_y[i])
        );
    end

    // Self-test sequencing: four APPLY/CHECK pairs, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (test_start) state_d = APPLY;
            APPLY:   state_d = CHECK;
            CHECK:   state_d = (vec_q == 2'd3) ? DONE : APPLY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus the core output register, which runs in every mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            core_q  <= '0;
        end else begin
            state_q <= state_d;
            core_q  <= cell_y ^ inject_fault;
        end
    end

    // Pin-facing outputs: Y follows the gates only in normal mode, function latches only in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y         <= '0;
            active_fn <= FN_NAND;
        end else begin
            if (normal_mode) Y <= cell_y ^ inject_fault;
            if ((state_q == IDLE) && fn_load) active_fn <= fn_sel;
        end
    end

    // Vector counter and sticky result flags; cleared only by a new test or reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q     <= 2'd0;
            fail_ch   <= '0;
            test_pass <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (test_start) begin
                        vec_q     <= 2'd0;
                        fail_ch   <= '0;
                        test_pass <= 1'b0;
                    end
                end
                CHECK: begin
                    fail_ch <= fail_ch | mismatch;
                    if (vec_q != 2'd3) vec_q <= vec_q + 2'd1;
                end
                DONE:    test_pass <= ~|fail_ch;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_w_74hc_gate_bank.sv
// Directed bench for w_74hc_gate_bank: function table sweep plus self-test sequences.
module tb_w_74hc_gate_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] fn_sel;
    logic       fn_load;
    logic [3:0] inject_fault;
    logic       test_start;
    logic [3:0] Y;
    logic [2:0] active_fn;
    logic       test_busy;
    logic       test_done;
    logic       test_pass;
    logic [3:0] fail_ch;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0] fn;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
    } vec_t;

    vec_t tbl [10];

    w_74hc_gate_bank #(.N_CH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .A            (A),
        .B            (B),
        .fn_sel       (fn_sel),
        .fn_load      (fn_load),
        .inject_fault (inject_fault),
        .test_start   (test_start),
        .Y            (Y),
        .active_fn    (active_fn),
        .test_busy    (test_busy),
        .test_done    (test_done),
        .test_pass    (test_pass),
        .fail_ch      (fail_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic run_test(input string nm, input logic mid, input logic [3:0] exp_fail,
                            input logic exp_pass, input logic [2:0] exp_fn);
        int busy_cnt;
        int busy_first;
        int busy_last;
        int done_cnt;
        int done_at;
        logic y_ok;
        logic [3:0] y_ref;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        done_cnt = 0; done_at = -1; y_ok = 1'b1;
        test_start = 1'b1;
        step();
        test_start = 1'b0;
        fn_load = 1'b0;
        y_ref = Y;
        for (int c = 1; c <= 14; c++) begin
            if (test_busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (test_done) begin
                done_cnt++;
                done_at = c;
            end
            if (c <= 9 && Y !== y_ref) y_ok = 1'b0;
            if (mid && c == 3) begin
                fn_sel = 3'b011;
                fn_load = 1'b1;
                test_start = 1'b1;
            end
            step();
            if (mid && c == 3) begin
                fn_load = 1'b0;
                test_start = 1'b0;
            end
        end
        chk({nm, " busy_cycles"}, busy_cnt, 8);
        chk({nm, " busy_window"}, busy_first * 100 + busy_last, 108);
        chk({nm, " done_count"}, done_cnt, 1);
        chk({nm, " done_cycle"}, done_at, 9);
        chk({nm, " y_hold"}, {31'd0, y_ok}, 1);
        chk({nm, " test_pass"}, {31'd0, test_pass}, {31'd0, exp_pass});
        chk({nm, " fail_ch"}, {28'd0, fail_ch}, {28'd0, exp_fail});
        chk({nm, " active_fn"}, {29'd0, active_fn}, {29'd0, exp_fn});
    endtask

    initial begin
        int dcnt;
        tbl[0] = '{3'b000, 4'b1010, 4'b1100, 4'b0111};
        tbl[1] = '{3'b001, 4'b1010, 4'b1100, 4'b1000};
        tbl[2] = '{3'b010, 4'b1010, 4'b1100, 4'b0001};
        tbl[3] = '{3'b011, 4'b1010, 4'b1100, 4'b1110};
        tbl[4] = '{3'b100, 4'b1010, 4'b1100, 4'b0110};
        tbl[5] = '{3'b101, 4'b1010, 4'b1100, 4'b1001};
        tbl[6] = '{3'b110, 4'b1010, 4'b1100, 4'b0101};
        tbl[7] = '{3'b111, 4'b1010, 4'b1100, 4'b1010};
        tbl[8] = '{3'b100, 4'b0110, 4'b0011, 4'b0101};
        tbl[9] = '{3'b000, 4'b0110, 4'b0011, 4'b1101};

        rst_n = 1'b0; A = 4'b1010; B = 4'b1100; fn_sel = 3'b000; fn_load = 1'b0;
        inject_fault = 4'b0000; test_start = 1'b0;
        step();
        step();
        chk("reset Y", {28'd0, Y}, 0);
        chk("reset active_fn", {29'd0, active_fn}, 0);
        chk("reset busy_done", {30'd0, test_busy, test_done}, 0);
        chk("reset pass_fail", {27'd0, test_pass, fail_ch}, 0);

        rst_n = 1'b1;
        step();
        chk("nand default Y", {28'd0, Y}, {28'd0, 4'b0111});
        chk("nand default pass_fail", {27'd0, test_pass, fail_ch}, 0);

        // Load each function, then check Y one edge after the load takes effect.
        for (int i = 0; i < 10; i++) begin
            fn_sel = tbl[i].fn; A = tbl[i].a; B = tbl[i].b; fn_load = 1'b1;
            step();
            fn_load = 1'b0;
            chk($sformatf("tbl%0d active_fn", i), {29'd0, active_fn}, {29'd0, tbl[i].fn});
            step();
            chk($sformatf("tbl%0d Y", i), {28'd0, Y}, {28'd0, tbl[i].y});
        end

        A = 4'b1010; B = 4'b1100;
        step();
        run_test("nand_pass", 1'b0, 4'b0000, 1'b1, 3'b000);

        inject_fault = 4'b0100;
        step();
        chk("inject Y", {28'd0, Y}, {28'd0, 4'b0011});
        run_test("fault", 1'b0, 4'b0100, 1'b0, 3'b000);

        inject_fault = 4'b0000;
        step();
        run_test("clear", 1'b0, 4'b0000, 1'b1, 3'b000);

        run_test("mid_strobe", 1'b1, 4'b0000, 1'b1, 3'b000);

        fn_sel = 3'b101; fn_load = 1'b1;
        run_test("xnor_same", 1'b0, 4'b0000, 1'b1, 3'b101);
        chk("xnor Y after test", {28'd0, Y}, {28'd0, 4'b1001});

        // Abort a running test with reset at cycle t+5.
        test_start = 1'b1;
        step();
        test_start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        chk("abort busy before reset", {31'd0, test_busy}, 1);
        rst_n = 1'b0;
        step();
        chk("abort Y", {28'd0, Y}, 0);
        chk("abort active_fn", {29'd0, active_fn}, 0);
        chk("abort busy_done", {30'd0, test_busy, test_done}, 0);
        chk("abort pass_fail", {27'd0, test_pass, fail_ch}, 0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (test_done || test_busy) dcnt++;
            step();
        end
        chk("abort no done pulse", dcnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
